// File: rtl/edge_det_pkg.sv
// edge_det_pkg: shared mode encoding for the multi-channel edge detector.
package edge_det_pkg;

  // Per-channel mode: which accepted edge(s) raise the event pulse.
  typedef enum logic [1:0] {
    EDGE_MODE_OFF  = 2'b00,
    EDGE_MODE_RISE = 2'b01,
    EDGE_MODE_FALL = 2'b10,
    EDGE_MODE_BOTH = 2'b11
  } edge_mode_t;

endpackage : edge_det_pkg

// File: rtl/edge_det_chan.sv
// edge_det_chan: one channel of edge_detect_multi. Synchroniser chain,
// optional debounce (EDGE_DET_DEBOUNCE_EN), registered rise/fall/event
// pulses and a sticky write-1-to-clear flag.
import edge_det_pkg::*;

module edge_det_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       flag_clr,
  output logic       level,
  output logic       rising,
  output logic       falling,
  output logic       evt,
  output logic       flag
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("edge_det_chan: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   accept;
  logic                   rise_cond;
  logic                   fall_cond;
  logic                   evt_cond;

  assign synced = sync[SYNC_STAGES-1];

`ifdef EDGE_DET_DEBOUNCE_EN
  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Accept a new level only once it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    accept = 1'b0;
    if ((synced != level) && (cnt == CNT_MAX)) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
  end

  // Stability counter: restarts whenever the input agrees with L or is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((synced == level) || accept) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  // Without debounce any difference between the chain and L is accepted.
  always_comb begin
    accept = 1'b0;
    if (synced != level) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
  end
`endif

  // Edge conditions and mode qualification, evaluated on the accepting edge.
  always_comb begin
    rise_cond = 1'b0;
    fall_cond = 1'b0;
    evt_cond  = 1'b0;
    if (accept) begin
      rise_cond = synced;
      fall_cond = ~synced;
    end else begin
      rise_cond = 1'b0;
      fall_cond = 1'b0;
    end
    case (edge_mode_t'(mode))
      EDGE_MODE_OFF:  evt_cond = 1'b0;
      EDGE_MODE_RISE: evt_cond = rise_cond;
      EDGE_MODE_FALL: evt_cond = fall_cond;
      EDGE_MODE_BOTH: evt_cond = rise_cond | fall_cond;
      default:        evt_cond = 1'b0;
    endcase
  end

  // Sync chain, accepted level, one-cycle pulses and sticky flag (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      level   <= 1'b0;
      rising  <= 1'b0;
      falling <= 1'b0;
      evt     <= 1'b0;
      flag    <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], start};
      if (accept) begin
        level <= synced;
      end else begin
        level <= level;
      end
      rising  <= rise_cond;
      falling <= fall_cond;
      evt     <= evt_cond;
      if (evt) begin
        flag <= 1'b1;
      end else if (flag_clr) begin
        flag <= 1'b0;
      end else begin
        flag <= flag;
      end
    end
  end

endmodule : edge_det_chan

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: CHANNELS independent edge-detect channels plus an
// interrupt OR of their sticky flags. Define EDGE_DET_DEBOUNCE_EN to add
// per-channel debounce governed by DEBOUNCE_CYCLES.
import edge_det_pkg::*;

module edge_detect_multi #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [CHANNELS-1:0]   i_Start,
  input  logic [2*CHANNELS-1:0] i_Mode,
  input  logic [CHANNELS-1:0]   i_Flag_Clr,
  output logic [CHANNELS-1:0]   o_Level,
  output logic [CHANNELS-1:0]   o_Rising,
  output logic [CHANNELS-1:0]   o_Falling,
  output logic [CHANNELS-1:0]   o_Event,
  output logic [CHANNELS-1:0]   o_Flag,
  output logic                  o_Irq
);

  if (CHANNELS < 1) begin : g_param_err
    $error("edge_detect_multi: CHANNELS must be >= 1");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (i_Clk),
      .rst      (i_Rst),
      .start    (i_Start[c]),
      .mode     (i_Mode[2*c+1:2*c]),
      .flag_clr (i_Flag_Clr[c]),
      .level    (o_Level[c]),
      .rising   (o_Rising[c]),
      .falling  (o_Falling[c]),
      .evt      (o_Event[c]),
      .flag     (o_Flag[c])
    );
  end

  // Interrupt follows the flag registers directly, with no extra delay.
  assign o_Irq = |o_Flag;

endmodule : edge_detect_multi

// File: doc/edge_detect_multi.md
# edge_detect_multi

Multi-channel, parametrised successor to the single-input start-edge detector. Each channel synchronises an asynchronous input, optionally debounces it, and produces registered one-cycle rising/falling pulses, a mode-qualified event pulse, and a sticky event flag with write-1-to-clear. The block sits between external control/status pins and the control FSMs and interrupt logic that consume them.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a level change is accepted (≥1). Used only when `EDGE_DET_DEBOUNCE_EN` is defined.

- `i_Clk`  in  1  sole clock; all logic is on its rising edge.
- `i_Rst`  in  1  synchronous, active-high reset.
- `i_Start`  in  CHANNELS  asynchronous raw inputs, one bit per channel.
- `i_Mode`  in  2*CHANNELS  per-channel mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
- `i_Flag_Clr`  in  CHANNELS  write-1-to-clear strobe for `o_Flag`.
- `o_Level`  out  CHANNELS  accepted (synchronised, debounced) level.
- `o_Rising`  out  CHANNELS  one-cycle pulse on an accepted 0→1 change; independent of mode.
- `o_Falling`  out  CHANNELS  one-cycle pulse on an accepted 1→0 change; independent of mode.
- `o_Event`  out  CHANNELS  one-cycle pulse when the accepted edge matches `i_Mode`.
- `o_Flag`  out  CHANNELS  sticky, set by `o_Event`.
- `o_Irq`  out  1  OR of all `o_Flag` bits (combinational from flag registers).

## Operation
- Per channel: shift chain s[0..SYNC_STAGES-1] fed by `i_Start[c]`; s[last] is the synchronised level.
- Level register L (`o_Level`). Without debounce: L <= s[last] every cycle.
- `o_Rising` <= s[last] & ~L and `o_Falling` <= ~s[last] & L (without debounce), registered, so each pulse coincides with the L update.
- With debounce: counter cnt, width clog2(DEBOUNCE_CYCLES), saturating logic:
  - s[last] == L: cnt <= 0, no pulse.
  - s[last] != L and cnt == DEBOUNCE_CYCLES-1: L <= s[last], cnt <= 0, matching pulse.
  - otherwise cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse and no L change.
- `o_Event` <= (mode[0] & rising-condition) | (mode[1] & falling-condition); mode 00 never fires. `i_Mode` is sampled on the same edge as the condition; no retroactive events after a mode change.
- Flag: set when `o_Event` is asserted (i.e. registered from the event condition); otherwise cleared by `i_Flag_Clr[c]`. Set wins over a simultaneous clear.
- Channels are fully independent; simultaneous edges on all channels are handled in the same cycle.

## Timing
- Reset values: all sync flops, L, cnt, `o_Level`, `o_Rising`, `o_Falling`, `o_Event`, `o_Flag`, `o_Irq` = 0.
- Latency from the first clock edge that samples a new input level to the pulse/`o_Level` update: SYNC_STAGES+1 edges without debounce, SYNC_STAGES+DEBOUNCE_CYCLES edges with it.
- Pulses are exactly one cycle wide. The minimum input period that yields distinct pulses is 1 cycle without debounce and DEBOUNCE_CYCLES cycles with it.
- `i_Rst` mid-operation: all state returns to 0 on that edge, and in-flight pulses and flags are lost. If an input is held high across reset release, a rising pulse follows at the normal latency, because the chain restarts from 0.
- `i_Flag_Clr` takes effect on the next edge. `o_Irq` follows `o_Flag` in the same cycle.

## Configuration
- `EDGE_DET_DEBOUNCE_EN` defined: per-channel debounce counter present, and `DEBOUNCE_CYCLES` governs acceptance.
- Not defined: no counters. L follows s[last] with one register delay, and `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `edge_det_pkg`:
  - mode encoding constants `EDGE_MODE_OFF`=2'b00, `EDGE_MODE_RISE`=2'b01, `EDGE_MODE_FALL`=2'b10, `EDGE_MODE_BOTH`=2'b11;
  - `edge_mode_t` typedef.
- Sub-module `edge_det_chan`: one channel covering sync chain, debounce, pulses and flag. It is generate-instantiated CHANNELS times, and the top level holds only the `o_Irq` OR.

## Test plan
- Ch0 mode 01, `i_Start[0]` 0→1 held, no debounce, SYNC_STAGES=2 → `o_Rising[0]`/`o_Event[0]` high for exactly 1 cycle on the 3rd edge; `o_Flag[0]`=1 and `o_Irq`=1 on the next edge.
- Ch1 mode 10, rising then falling edge → `o_Rising[1]` fires but `o_Event[1]` stays 0; on the falling edge both `o_Falling[1]` and `o_Event[1]` pulse.
- Debounce on, DEBOUNCE_CYCLES=4, 3-cycle high glitch → no pulse, `o_Level` stays 0. A 4-cycle high → single `o_Rising` at SYNC_STAGES+4 edges.
- Flag set and `i_Flag_Clr` asserted in the same cycle → `o_Flag` stays 1. Clear alone next cycle → `o_Flag`=0 and `o_Irq`=0.
- All 4 channels mode 11, simultaneous toggles → four concurrent `o_Event` pulses and all flags set.
- `i_Rst` asserted mid-debounce with input high → outputs 0. After release, with input still high, `o_Rising` fires at full latency.
